// File: rtl/nios_sysid_ext_if.sv
// Avalon-MM slave bus for the system-identification block.
// Fixed-latency read: an accepted read (read=1 at an edge) is answered with
// readdatavalid=1 and readdata at the next edge; there is no waitrequest.
interface nios_sysid_ext_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/nios_sysid_ext.sv
// System-ID slave: fixed ID/timestamp words, coherent 64-bit uptime snapshot,
// scratch register and a control word with counter enable/clear.
module nios_sysid_ext #(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter int          UPTIME_WIDTH = 64,
    parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000
) (
    input  logic             clock,
    input  logic             reset_n,
    nios_sysid_ext_if.slave  bus
);

    localparam logic [UPTIME_WIDTH-1:0] CNT_ONE = {{(UPTIME_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]              WIDTH_FIELD = 8'(UPTIME_WIDTH);

    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_TSTAMP  = 3'd1;
    localparam logic [2:0] ADDR_UP_LO   = 3'd2;
    localparam logic [2:0] ADDR_UP_HI   = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH = 3'd4;
    localparam logic [2:0] ADDR_CTRL    = 3'd5;

    logic [UPTIME_WIDTH-1:0] cnt;
    logic [63:0]             cnt_ext;
    logic [31:0]             hi_shadow;
    logic [31:0]             scratch;
    logic                    en;
    logic                    wr_en;
    logic                    clr;
    logic [31:0]             rd_mux;

    // Bits above UPTIME_WIDTH read as zero through the zero-extension.
    assign cnt_ext = 64'(cnt);

    // A write colliding with a read is dropped.
    assign wr_en = bus.write & ~bus.read;
    assign clr   = wr_en && (bus.address == ADDR_CTRL) && bus.writedata[1];

    always_comb begin
        rd_mux = 32'h0;
        case (bus.address)
            ADDR_ID:      rd_mux = SYSTEM_ID;
            ADDR_TSTAMP:  rd_mux = TIMESTAMP;
            ADDR_UP_LO:   rd_mux = cnt_ext[31:0];
            ADDR_UP_HI:   rd_mux = hi_shadow;
            ADDR_SCRATCH: rd_mux = scratch;
            ADDR_CTRL:    rd_mux = {16'h0, WIDTH_FIELD, 7'h0, en};
            default:      rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata      <= 32'h0;
            bus.readdatavalid <= 1'b0;
            cnt               <= '0;
            hi_shadow         <= 32'h0;
            scratch           <= SCRATCH_INIT;
            en                <= 1'b1;
        end else begin
            bus.readdatavalid <= bus.read;
            if (bus.read) begin
                bus.readdata <= rd_mux;
            end
            // LO read and HI latch both see the pre-increment count.
            if (bus.read && (bus.address == ADDR_UP_LO)) begin
                hi_shadow <= cnt_ext[63:32];
            end

            if (wr_en && (bus.address == ADDR_SCRATCH)) begin
                scratch <= bus.writedata;
            end
            if (wr_en && (bus.address == ADDR_CTRL)) begin
                en <= bus.writedata[0];
            end

            if (clr) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule
